// File: rtl/uarc_pkg.sv
// Shared definitions for the ARC micro-datapath sequencer: microword layout,
// branch-condition and state encodings, and the decode-address builder.
package uarc_pkg;

  localparam int CSAR_W = 11;

  localparam int MIR_A_HI    = 40;
  localparam int MIR_A_LO    = 35;
  localparam int MIR_AMUX    = 34;
  localparam int MIR_B_HI    = 33;
  localparam int MIR_B_LO    = 28;
  localparam int MIR_BMUX    = 27;
  localparam int MIR_C_HI    = 26;
  localparam int MIR_C_LO    = 21;
  localparam int MIR_CMUX    = 20;
  localparam int MIR_RD      = 19;
  localparam int MIR_WR      = 18;
  localparam int MIR_ALU_HI  = 17;
  localparam int MIR_ALU_LO  = 14;
  localparam int MIR_COND_HI = 13;
  localparam int MIR_COND_LO = 11;
  localparam int MIR_ADDR_HI = 10;
  localparam int MIR_ADDR_LO = 0;

  typedef enum logic [2:0] {
    COND_NEXT   = 3'b000,
    COND_N      = 3'b001,
    COND_Z      = 3'b010,
    COND_V      = 3'b011,
    COND_C      = 3'b100,
    COND_IR13   = 3'b101,
    COND_JUMP   = 3'b110,
    COND_DECODE = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_ERROR   = 2'd3
  } state_e;

  localparam logic [CSAR_W-1:0] FETCH_ADDR = '0;
  localparam logic              DEC_LEAD   = 1'b1;
  localparam logic [1:0]        DEC_TAIL   = 2'b00;

  // Instruction decode target: {1, op, op3, 00}, i.e. four words per opcode.
  function automatic logic [CSAR_W-1:0] decode_addr(input logic [1:0] op,
                                                    input logic [5:0] op3);
    return {DEC_LEAD, op, op3, DEC_TAIL};
  endfunction

endpackage

// File: rtl/csai_next_addr.sv
// Combinational next control-store address selection from the microword
// COND/ADDR fields, the PSR flags and the instruction register.
module csai_next_addr
  import uarc_pkg::*;
#(
  parameter int CSAR_WIDTH = 11
) (
  input  logic [2:0]            cond_i,
  input  logic [CSAR_WIDTH-1:0] addr_i,
  input  logic [CSAR_WIDTH-1:0] csar_i,
  input  logic [3:0]            flags_i,
  input  logic [31:0]           ir_i,
  output logic [CSAR_WIDTH-1:0] next_o
);

  logic [CSAR_WIDTH-1:0] inc;
  logic                  unused_ir;

  assign inc       = csar_i + CSAR_WIDTH'(1);
  assign unused_ir = ^{ir_i[29:25], ir_i[18:14], ir_i[12:0]};

  // flags_i is {n, z, v, c}
  always_comb begin
    next_o = inc;
    case (cond_i)
      COND_N:      next_o = flags_i[3] ? addr_i : inc;
      COND_Z:      next_o = flags_i[2] ? addr_i : inc;
      COND_V:      next_o = flags_i[1] ? addr_i : inc;
      COND_C:      next_o = flags_i[0] ? addr_i : inc;
      COND_IR13:   next_o = ir_i[13]   ? addr_i : inc;
      COND_JUMP:   next_o = addr_i;
      COND_DECODE: next_o = CSAR_WIDTH'(decode_addr(ir_i[31:30], ir_i[24:19]));
      default:     next_o = inc;
    endcase
  end

endmodule

// File: rtl/microsequencer.sv
// Microprogram counter, memory-wait FSM with timeout, and executed-microword
// counter for the ARC micro-datapath control store.
module microsequencer
  import uarc_pkg::*;
#(
  parameter int CSAR_WIDTH = 11,
  parameter int MIR_WIDTH  = 41,
  parameter int WAIT_LIMIT = 15
) (
  input  logic                  uSEQ_CLOCK_50,
  input  logic                  uSEQ_RESET_InLow,
  input  logic                  uSEQ_START,
  input  logic                  uSEQ_HALT,
  input  logic [MIR_WIDTH-1:0]  uSEQ_MIR,
  input  logic [31:0]           uSEQ_IR,
  input  logic [3:0]            uSEQ_FLAGS,
  input  logic                  uSEQ_MEMACK,
  output logic [CSAR_WIDTH-1:0] uSEQ_CSAR,
  output logic                  uSEQ_EXEC,
  output logic                  uSEQ_MEMRD,
  output logic                  uSEQ_MEMWR,
  output logic                  uSEQ_BUSY,
  output logic                  uSEQ_ERROR,
  output logic [1:0]            uSEQ_STATE,
  output logic [15:0]           uSEQ_UCOUNT
);

  localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);

  state_e                state_q, state_d;
  logic [CSAR_WIDTH-1:0] csar_q, csar_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [15:0]           ucount_q, ucount_d;

  logic                  mir_rd, mir_wr, memop, busy, exec;
  logic [2:0]            mir_cond;
  logic [CSAR_WIDTH-1:0] mir_addr, next_addr;
  logic                  unused_mir;

  assign mir_rd     = uSEQ_MIR[MIR_RD];
  assign mir_wr     = uSEQ_MIR[MIR_WR];
  assign mir_cond   = uSEQ_MIR[MIR_COND_HI:MIR_COND_LO];
  assign mir_addr   = CSAR_WIDTH'(uSEQ_MIR[MIR_ADDR_HI:MIR_ADDR_LO]);
  assign unused_mir = ^{uSEQ_MIR[MIR_A_HI:MIR_CMUX], uSEQ_MIR[MIR_ALU_HI:MIR_ALU_LO]};

  assign memop = mir_rd | mir_wr;
  assign busy  = (state_q == ST_RUN) || (state_q == ST_MEMWAIT);
  assign exec  = busy && (!memop || uSEQ_MEMACK);

  csai_next_addr #(.CSAR_WIDTH(CSAR_WIDTH)) u_next (
    .cond_i  (mir_cond),
    .addr_i  (mir_addr),
    .csar_i  (csar_q),
    .flags_i (uSEQ_FLAGS),
    .ir_i    (uSEQ_IR),
    .next_o  (next_addr)
  );

  always_comb begin
    state_d  = state_q;
    csar_d   = csar_q;
    wait_d   = wait_q;
    ucount_d = ucount_q;
    case (state_q)
      ST_IDLE: begin
        if (uSEQ_START) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (memop && !uSEQ_MEMACK) begin
          state_d = ST_MEMWAIT;
          wait_d  = '0;
        end
      end
      ST_MEMWAIT: begin
        if (uSEQ_MEMACK) begin
          state_d = ST_RUN;
        end else if (wait_q == WAIT_W'(WAIT_LIMIT - 1)) begin
          state_d = ST_ERROR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: ;
    endcase
    // A halt at a decode boundary parks the sequencer on the fetch address
    // so the interrupted instruction is fetched again on restart.
    if (exec) begin
      ucount_d = ucount_q + 16'd1;
      if (mir_cond == COND_DECODE && uSEQ_HALT) begin
        csar_d  = CSAR_WIDTH'(FETCH_ADDR);
        state_d = ST_IDLE;
      end else begin
        csar_d  = next_addr;
      end
    end
  end

  always_ff @(posedge uSEQ_CLOCK_50) begin
    if (!uSEQ_RESET_InLow) begin
      state_q  <= ST_IDLE;
      csar_q   <= CSAR_WIDTH'(FETCH_ADDR);
      wait_q   <= '0;
      ucount_q <= '0;
    end else begin
      state_q  <= state_d;
      csar_q   <= csar_d;
      wait_q   <= wait_d;
      ucount_q <= ucount_d;
    end
  end

  assign uSEQ_CSAR   = csar_q;
  assign uSEQ_EXEC   = exec;
  assign uSEQ_MEMRD  = busy && mir_rd;
  assign uSEQ_MEMWR  = busy && mir_wr;
  assign uSEQ_BUSY   = busy;
  assign uSEQ_ERROR  = (state_q == ST_ERROR);
  assign uSEQ_STATE  = state_q;
  assign uSEQ_UCOUNT = ucount_q;

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: branch table plus halt, memory-wait,
// timeout and reset-during-wait sequences.
module tb_microsequencer;

  logic        clk, rst_n, start, halt, ack;
  logic [40:0] mir;
  logic [31:0] ir;
  logic [3:0]  flags;
  logic [10:0] csar;
  logic        exec, memrd, memwr, busy, error;
  logic [1:0]  state;
  logic [15:0] ucount;

  int n_cmp = 0;
  int n_err = 0;
  int uc    = 0;

  microsequencer dut (
    .uSEQ_CLOCK_50    (clk),
    .uSEQ_RESET_InLow (rst_n),
    .uSEQ_START       (start),
    .uSEQ_HALT        (halt),
    .uSEQ_MIR         (mir),
    .uSEQ_IR          (ir),
    .uSEQ_FLAGS       (flags),
    .uSEQ_MEMACK      (ack),
    .uSEQ_CSAR        (csar),
    .uSEQ_EXEC        (exec),
    .uSEQ_MEMRD       (memrd),
    .uSEQ_MEMWR       (memwr),
    .uSEQ_BUSY        (busy),
    .uSEQ_ERROR       (error),
    .uSEQ_STATE       (state),
    .uSEQ_UCOUNT      (ucount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [10:0] from;
    logic [2:0]  cond;
    logic [10:0] addr;
    logic [31:0] ir;
    logic [3:0]  flags;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [40:0] mk(input logic rd, input logic wr,
                                     input logic [2:0] cond, input logic [10:0] addr);
    logic [40:0] m;
    m        = '0;
    m[19]    = rd;
    m[18]    = wr;
    m[13:11] = cond;
    m[10:0]  = addr;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lowcnt, rdcnt, mwcnt;

    vecs[0]  = '{"decode",      11'd5,    3'b111, 11'd0,    32'h8080_0000, 4'b0000, 11'd1600};
    vecs[1]  = '{"ir13_taken",  11'd1600, 3'b101, 11'd1602, 32'h0000_2000, 4'b0000, 11'd1602};
    vecs[2]  = '{"ir13_not",    11'd1600, 3'b101, 11'd1602, 32'hFFFF_DFFF, 4'b1111, 11'd1601};
    vecs[3]  = '{"z_taken",     11'd8,    3'b010, 11'd12,   32'h0,         4'b0100, 11'd12};
    vecs[4]  = '{"z_not",       11'd8,    3'b010, 11'd12,   32'h0,         4'b1011, 11'd9};
    vecs[5]  = '{"wrap",        11'd2047, 3'b000, 11'd55,   32'h0,         4'b1111, 11'd0};
    vecs[6]  = '{"n_taken",     11'd100,  3'b001, 11'd200,  32'h0,         4'b1000, 11'd200};
    vecs[7]  = '{"n_not",       11'd100,  3'b001, 11'd200,  32'h0,         4'b0111, 11'd101};
    vecs[8]  = '{"v_taken",     11'd20,   3'b011, 11'd300,  32'h0,         4'b0010, 11'd300};
    vecs[9]  = '{"c_taken",     11'd30,   3'b100, 11'd400,  32'h0,         4'b0001, 11'd400};
    vecs[10] = '{"c_not",       11'd30,   3'b100, 11'd400,  32'h0,         4'b1110, 11'd31};
    vecs[11] = '{"jump",        11'd50,   3'b110, 11'd7,    32'h0,         4'b0000, 11'd7};

    rst_n = 1'b0; start = 1'b0; halt = 1'b0; ack = 1'b0;
    mir = '0; ir = '0; flags = '0;
    step();
    step();
    chk("rst_csar", csar, 0);
    chk("rst_state", state, 0);
    chk("rst_exec", exec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_ucount", ucount, 0);
    chk("rst_memrd", memrd, 0);

    // Start: one cycle to RUN, microword 0 executes immediately.
    rst_n = 1'b1; start = 1'b1; mir = mk(0, 0, 3'b000, 11'd0);
    step();
    start = 1'b0;
    chk("start_state", state, 1);
    chk("start_exec", exec, 1);
    chk("start_csar", csar, 0);
    step(); uc++;
    chk("first_csar", csar, 1);
    chk("first_ucount", ucount, uc);

    foreach (vecs[i]) begin
      mir = mk(0, 0, 3'b110, vecs[i].from); ir = '0; flags = '0;
      step(); uc++;
      chk({vecs[i].name, "_setup"}, csar, vecs[i].from);
      mir = mk(0, 0, vecs[i].cond, vecs[i].addr); ir = vecs[i].ir; flags = vecs[i].flags;
      #1;
      chk({vecs[i].name, "_exec"}, exec, 1);
      step(); uc++;
      chk(vecs[i].name, csar, vecs[i].exp);
    end
    chk("table_ucount", ucount, uc);

    // Halt at decode, then START beats HALT in IDLE, halt hits next decode.
    mir = mk(0, 0, 3'b110, 11'd5); ir = '0; flags = '0;
    step(); uc++;
    mir = mk(0, 0, 3'b111, 11'd0); ir = 32'h8080_0000; halt = 1'b1;
    step(); uc++;
    chk("halt_csar", csar, 0);
    chk("halt_state", state, 0);
    start = 1'b1;
    step();
    chk("start_wins", state, 1);
    start = 1'b0;
    step(); uc++;
    chk("halt2_state", state, 0);
    chk("halt2_csar", csar, 0);
    halt = 1'b0; start = 1'b1; mir = mk(0, 0, 3'b000, 11'd0);
    step();
    start = 1'b0;
    chk("restart_state", state, 1);

    // Read acked on the third MEMWAIT cycle.
    mir = mk(1, 0, 3'b000, 11'd0); ack = 1'b0;
    lowcnt = 0; rdcnt = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      ack = (cyc == 3);
      #1;
      if (!exec) lowcnt++;
      if (memrd) rdcnt++;
      if (cyc > 0) chk("mw_state", state, 2);
      step();
    end
    uc++;
    ack = 1'b0;
    chk("mw_exec_low", lowcnt, 3);
    chk("mw_memrd_high", rdcnt, 4);
    chk("mw_csar", csar, 1);
    chk("mw_back_run", state, 1);

    // Write acked in the issuing cycle: single cycle.
    mir = mk(0, 1, 3'b000, 11'd0); ack = 1'b1;
    #1;
    chk("wr_memwr", memwr, 1);
    chk("wr_exec", exec, 1);
    step(); uc++;
    ack = 1'b0;
    chk("wr_csar", csar, 2);
    chk("wr_state", state, 1);

    // Timeout: no ACK ever.
    mir = mk(1, 0, 3'b000, 11'd0);
    step();
    mwcnt = 0;
    for (int i = 0; i < 40 && state != 2'd3; i++) begin
      if (state == 2'd2) mwcnt++;
      step();
    end
    chk("to_state", state, 3);
    chk("to_mwcycles", mwcnt, 15);
    chk("to_error", error, 1);
    chk("to_memrd", memrd, 0);
    chk("to_exec", exec, 0);
    chk("to_busy", busy, 0);
    chk("to_csar", csar, 2);
    ack = 1'b1; start = 1'b1;
    step(); step();
    chk("to_sticky", state, 3);
    chk("to_ucount", ucount, uc);
    ack = 1'b0; start = 1'b0;

    // Reset during MEMWAIT.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; start = 1'b1; mir = mk(1, 0, 3'b000, 11'd0);
    step();
    start = 1'b0;
    step();
    chk("rmw_state", state, 2);
    chk("rmw_memrd", memrd, 1);
    rst_n = 1'b0;
    step();
    chk("rmw_memrd_drop", memrd, 0);
    chk("rmw_state_idle", state, 0);
    chk("rmw_csar", csar, 0);
    chk("rmw_ucount", ucount, 0);
    chk("rmw_error", error, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
